// File: rtl/wbu_chanmux.sv
// Shares one 8-bit serial link among NCHAN 7-bit byte channels: bit7=1 bytes select a channel,
// bit7=0 bytes carry data. Round-robin tx arbitration with burst limit, rx demux, off-until-accessed gate.
module wbu_chanmux #(
    parameter int                NCHAN              = 4,
    parameter int                LGCHAN             = 2,
    parameter int                MAX_BURST          = 16,
    parameter logic [NCHAN-1:0]  OFF_UNTIL_ACCESSED = '0,
    parameter int                RX_DEFAULT_CHAN    = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_rx_stb,
    input  logic [7:0]           i_rx_data,
    output logic                 o_tx_stb,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_busy,
    input  logic [NCHAN-1:0]     i_ch_stb,
    input  logic [7*NCHAN-1:0]   i_ch_data,
    output logic [NCHAN-1:0]     o_ch_busy,
    output logic [NCHAN-1:0]     o_ch_stb,
    output logic [6:0]           o_ch_data,
    output logic                 o_rx_drop
);
    localparam int             BW   = $clog2(MAX_BURST + 2);
    localparam logic [BW-1:0]  MAXB = BW'(MAX_BURST);

    logic              r_tx_stb;
    logic [7:0]        r_tx_data;
    logic              r_tx_valid;
    logic [LGCHAN-1:0] r_tx_chan;
    logic [BW-1:0]     r_burst;
    logic [NCHAN-1:0]  r_active;
    logic [LGCHAN-1:0] r_rx_chan;
    logic              r_rx_valid;
    logic [NCHAN-1:0]  r_ch_stb;
    logic [6:0]        r_ch_data;
    logic              r_rx_drop;

    logic [NCHAN-1:0]  w_req;
    logic              w_sole;
    logic              w_cont;
    logic              w_found;
    logic [LGCHAN-1:0] w_pick;
    logic [6:0]        w_cur_data;
    logic              w_load_data;
    logic              w_load_sel;
    logic              w_rx_sel_ok;

    assign w_req  = i_ch_stb & r_active;
    assign w_sole = (w_req == (NCHAN'(1) << r_tx_chan));
    assign w_cont = r_tx_valid && w_req[r_tx_chan]
                    && ((MAX_BURST == 0) || (r_burst < MAXB) || w_sole);

    // Round-robin search starts just after the current channel (or at 0 before any select).
    always_comb begin
        int base;
        int idx;
        w_found = 1'b0;
        w_pick  = '0;
        base    = r_tx_valid ? int'(r_tx_chan) + 1 : 0;
        idx     = 0;
        for (int i = 0; i < NCHAN; i++) begin
            idx = (base + i) % NCHAN;
            if (!w_found && w_req[idx[LGCHAN-1:0]]) begin
                w_found = 1'b1;
                w_pick  = idx[LGCHAN-1:0];
            end
        end
    end

    always_comb begin
        w_cur_data = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (k == int'(r_tx_chan)) w_cur_data = i_ch_data[7*k +: 7];
        end
    end

    assign w_load_data = !r_tx_stb && w_cont;
    assign w_load_sel  = !r_tx_stb && !w_cont && w_found;

    always_comb begin
        o_ch_busy = w_req;
        if (w_load_data) o_ch_busy[r_tx_chan] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tx_stb   <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_chan  <= '0;
            r_burst    <= '0;
        end else if (r_tx_stb) begin
            if (!i_tx_busy) r_tx_stb <= 1'b0;
        end else if (w_load_data) begin
            r_tx_stb  <= 1'b1;
            r_tx_data <= {1'b0, w_cur_data};
            if (r_burst < MAXB) r_burst <= r_burst + 1'b1;
        end else if (w_load_sel) begin
            r_tx_stb   <= 1'b1;
            r_tx_data  <= 8'h80 | 8'(w_pick);
            r_tx_valid <= 1'b1;
            r_tx_chan  <= w_pick;
            r_burst    <= '0;
        end
    end

    assign w_rx_sel_ok = (i_rx_data[6:0] < 7'(NCHAN));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rx_chan  <= LGCHAN'(RX_DEFAULT_CHAN);
            r_rx_valid <= 1'b1;
            r_active   <= ~OFF_UNTIL_ACCESSED;
            r_ch_stb   <= '0;
            r_ch_data  <= '0;
            r_rx_drop  <= 1'b0;
        end else begin
            r_ch_stb  <= '0;
            r_rx_drop <= 1'b0;
            if (i_rx_stb) begin
                if (!i_rx_data[7]) begin
                    if (r_rx_valid) begin
                        r_ch_stb  <= NCHAN'(1) << r_rx_chan;
                        r_ch_data <= i_rx_data[6:0];
                    end else begin
                        r_rx_drop <= 1'b1;
                    end
                end else if (w_rx_sel_ok) begin
                    r_rx_chan                           <= i_rx_data[LGCHAN-1:0];
                    r_rx_valid                          <= 1'b1;
                    r_active[i_rx_data[LGCHAN-1:0]]     <= 1'b1;
                end else begin
                    r_rx_valid <= 1'b0;
                    r_rx_drop  <= 1'b1;
                end
            end
        end
    end

    assign o_tx_stb  = r_tx_stb;
    assign o_tx_data = r_tx_data;
    assign o_ch_stb  = r_ch_stb;
    assign o_ch_data = r_ch_data;
    assign o_rx_drop = r_rx_drop;
endmodule
